// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one combinational alu4 between two requesters.
//
// A winner is picked in IDLE (round-robin or fixed priority), its operands are
// registered onto alu_a/alu_b/alu_op, the ALU output is captured one cycle later,
// and the captured result/flags are returned on the winner's response channel.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   req_valid/req_ready [1:0]  per-port request handshake
//   req_a*/req_b*/req_op*      per-port operands and opcode
//   resp_valid/resp_ready[1:0] per-port response handshake
//   resp_result, resp_flags    captured result and {c,n,z,v}
//   alu_a/alu_b/alu_op         registered operands to alu4
//   alu_result, alu_c/n/z/v    alu4 outputs
//   busy                       high whenever the FSM is not idle
//   done_cnt0/done_cnt1        completed responses per port (wrapping)
//   timeout_err                sticky response-timeout flag
module alu4_arbiter #(
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned RESP_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_a0,
  input  logic [3:0]       req_a1,
  input  logic [3:0]       req_b0,
  input  logic [3:0]       req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [3:0]       resp_result,
  output logic [3:0]       resp_flags,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  localparam bit         TmoEn   = (RESP_TIMEOUT != 0);
  // Last RESP cycle index before a forced drop; unused when the timeout is disabled.
  localparam logic [15:0] TmoLast = 16'(RESP_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [3:0]       res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic [CNT_W-1:0] done0_q, done0_d;
  logic [CNT_W-1:0] done1_q, done1_d;
  logic             tmo_err_q, tmo_err_d;
  logic [15:0]      tmo_q, tmo_d;

  logic win;
  logic grant;

  // Winner selection; only meaningful when some request is valid.
  always_comb begin
    win = 1'b0;
    unique case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
      default: win = 1'b0;
    endcase
  end

  // Gated by reset so nothing is accepted while reset is held.
  assign grant     = reset && (state_q == StIdle) && (req_valid != 2'b00);
  assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_d      = rr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    flg_d     = flg_q;
    done0_d   = done0_q;
    done1_d   = done1_q;
    tmo_err_d = tmo_err_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          id_d     = win;
          alu_a_d  = win ? req_a1 : req_a0;
          alu_b_d  = win ? req_b1 : req_b0;
          alu_op_d = win ? req_op1 : req_op0;
          state_d  = StExec;
        end
      end
      StExec: state_d = StCapt;
      StCapt: begin
        res_d   = alu_result;
        flg_d   = {alu_c, alu_n, alu_z, alu_v};
        tmo_d   = 16'd0;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready[id_q]) begin
          if (id_q) done1_d = done1_q + CNT_W'(1);
          else      done0_d = done0_q + CNT_W'(1);
          rr_d    = ~id_q;
          state_d = StIdle;
        end else if (TmoEn && (tmo_q == TmoLast)) begin
          tmo_err_d = 1'b1;
          rr_d      = ~id_q;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      id_q      <= 1'b0;
      rr_q      <= 1'b0;
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_op_q  <= 3'd0;
      res_q     <= 4'd0;
      flg_q     <= 4'd0;
      done0_q   <= '0;
      done1_q   <= '0;
      tmo_err_q <= 1'b0;
      tmo_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      tmo_err_q <= tmo_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign resp_valid  = (state_q == StResp) ? {id_q, ~id_q} : 2'b00;
  assign resp_result = res_q;
  assign resp_flags  = flg_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign busy        = (state_q != StIdle);
  assign done_cnt0   = done0_q;
  assign done_cnt1   = done1_q;
  assign timeout_err = tmo_err_q;

endmodule
